// File: rtl/stage2_feeder_pkg.sv
// Shared definitions for the stage-2 feeder: controller state encoding and
// default geometry of the 20-tap psum stage it feeds.
package stage2_feeder_pkg;

    localparam int NTAP_DEF     = 20;
    localparam int DW_DEF       = 32;
    localparam int PIPE_LAT_DEF = 4;
    localparam int FDEPTH_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/stage2_feeder_fifo.sv
// Result FIFO for the stage-2 feeder: circular buffer with occupancy count,
// simultaneous push and pop allowed, pointers wrap modulo DEPTH.
module feeder_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A push into a full FIFO is only honoured when a pop frees a slot.
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/stage2_feeder.sv
// Stage-2 feeder: loads the weight bank, launches activations into the
// fixed-latency psum stage under credit control, and queues returned psums.
module stage2_feeder
    import stage2_feeder_pkg::*;
#(
    parameter int NTAP     = NTAP_DEF,
    parameter int DW       = DW_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int FDEPTH   = FDEPTH_DEF,
    localparam int CRW     = $clog2(FDEPTH + 1)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iCfg_start,
    input  logic                 iW_valid,
    output logic                 oW_ready,
    input  logic [DW-1:0]        iW_data,
    input  logic                 iX_valid,
    output logic                 oX_ready,
    input  logic [DW-1:0]        iX_data,
    input  logic                 iDone,
    output logic [DW-1:0]        oX,
    output logic [NTAP*DW-1:0]   oW,
    output logic [DW-1:0]        oPsum,
    input  logic [DW-1:0]        iPsum_res,
    output logic                 oY_valid,
    input  logic                 iY_ready,
    output logic [DW-1:0]        oY_data,
    output logic                 oBusy,
    output state_t               oDbg_state,
    output logic [CRW-1:0]       oDbg_credits
);

    localparam int KW = (NTAP > 1) ? $clog2(NTAP) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends combinationally on valid.

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [NTAP-1:0][DW-1:0]  w_q, w_d;
    logic [DW-1:0]            x_q, x_d;
    logic                     launch_q, launch_d;
    logic [PIPE_LAT-1:0]      tag_q, tag_d;
    logic [CRW-1:0]           credits_q, credits_d;

    logic                     w_ready, x_ready, w_acc, x_acc;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CRW-1:0]           fifo_count;
    logic [DW-1:0]            fifo_data;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        w_d     = w_q;
        w_ready = (state_q == ST_LOAD_W);
        x_ready = (state_q == ST_RUN) && (credits_q != '0);
        w_acc   = iW_valid && w_ready;
        x_acc   = iX_valid && x_ready;
        case (state_q)
            ST_IDLE: begin
                if (iCfg_start) begin
                    state_d = ST_LOAD_W;
                    k_d     = '0;
                end
            end
            ST_LOAD_W: begin
                if (w_acc) begin
                    w_d[k_q] = iW_data;
                    if (k_q == KW'(NTAP - 1)) begin
                        k_d     = '0;
                        state_d = ST_RUN;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (iDone) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The launch register counts as in flight: a sample taken with iDone is still owed.
                if (!launch_q && (tag_q == '0) && (fifo_count == '0)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_d       = x_acc ? iX_data : x_q;
        launch_d  = x_acc;
        tag_d     = (tag_q << 1) | PIPE_LAT'(launch_q);
        fifo_push = tag_q[PIPE_LAT-1];
        fifo_pop  = !fifo_empty && iY_ready;
        credits_d = credits_q;
        if (x_acc && !fifo_pop) begin
            credits_d = credits_q - 1'b1;
        end else if (!x_acc && fifo_pop && (credits_q != CRW'(FDEPTH))) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            w_q       <= '0;
            x_q       <= '0;
            launch_q  <= 1'b0;
            tag_q     <= '0;
            credits_q <= CRW'(FDEPTH);
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            w_q       <= w_d;
            x_q       <= x_d;
            launch_q  <= launch_d;
            tag_q     <= tag_d;
            credits_q <= credits_d;
        end
    end

    feeder_fifo #(
        .DW    (DW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk       (iCLK),
        .rst       (iRST),
        .push      (fifo_push),
        .push_data (iPsum_res),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Credits bound the launches, so a returning psum always finds room.
    a_no_push_when_full: assert property (@(posedge iCLK) disable iff (iRST)
        !(fifo_push && fifo_full && !fifo_pop));

    assign oW_ready     = w_ready;
    assign oX_ready     = x_ready;
    assign oX           = x_q;
    assign oW           = w_q;
    assign oPsum        = '0;
    assign oY_valid     = !fifo_empty;
    assign oY_data      = fifo_data;
    assign oBusy        = (state_q != ST_IDLE);
    assign oDbg_state   = state_q;
    assign oDbg_credits = credits_q;

endmodule

// File: tb/tb_stage2_feeder.sv
// Bench for stage2_feeder: drives weights/activations, models the psum stage,
// and scoreboards results against a dot-product reference over accepted samples.
module tb_stage2_feeder;
    import stage2_feeder_pkg::*;

    localparam int NTAP     = 20;
    localparam int DW       = 32;
    localparam int PIPE_LAT = 4;
    localparam int FDEPTH   = 8;
    localparam int CRW      = $clog2(FDEPTH + 1);

    logic               iCLK, iRST, iCfg_start, iW_valid, oW_ready;
    logic [DW-1:0]      iW_data, iX_data, oX, oPsum, iPsum_res, oY_data;
    logic               iX_valid, oX_ready, iDone, oY_valid, iY_ready, oBusy;
    logic [NTAP*DW-1:0] oW;
    state_t             oDbg_state;
    logic [CRW-1:0]     oDbg_credits;

    stage2_feeder #(.NTAP(NTAP), .DW(DW), .PIPE_LAT(PIPE_LAT), .FDEPTH(FDEPTH)) dut (
        .iCLK(iCLK), .iRST(iRST), .iCfg_start(iCfg_start),
        .iW_valid(iW_valid), .oW_ready(oW_ready), .iW_data(iW_data),
        .iX_valid(iX_valid), .oX_ready(oX_ready), .iX_data(iX_data),
        .iDone(iDone), .oX(oX), .oW(oW), .oPsum(oPsum), .iPsum_res(iPsum_res),
        .oY_valid(oY_valid), .iY_ready(iY_ready), .oY_data(oY_data),
        .oBusy(oBusy), .oDbg_state(oDbg_state), .oDbg_credits(oDbg_credits)
    );

    // clock / reset
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // scoreboard state
    int n_pass = 0;
    int n_total = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] xs_model[$];
    logic [DW-1:0] w_model [NTAP];
    logic [DW-1:0] w_next [NTAP];
    logic [DW-1:0] pend_x[$];
    int n_acc = 0, n_beats = 0, first_acc_cyc = -1, first_y_cyc = -1;
    bit rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: each accepted sample yields sum over taps of w[i] * (i-th most recent sample).
    function automatic logic [DW-1:0] model_result();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < xs_model.size(); i++) r = r + w_model[i] * xs_model[i];
        return r;
    endfunction

    task automatic model_accept(input logic [DW-1:0] x);
        xs_model.push_front(x);
        if (xs_model.size() > NTAP) void'(xs_model.pop_back());
        exp_q.push_back(model_result());
    endtask

    task automatic model_reset();
        exp_q.delete();
        xs_model.delete();
        pend_x.delete();
        for (int i = 0; i < NTAP; i++) w_model[i] = '0;
    endtask

    // psum stage model: FIR over launched oX using oW, result presented PIPE_LAT cycles after launch
    logic [DW-1:0] sh [NTAP];
    logic [DW-1:0] dl [PIPE_LAT+1];
    bit acc_pend;
    initial begin
        iPsum_res = '0;
        acc_pend = 0;
        for (int i = 0; i < NTAP; i++) sh[i] = '0;
        for (int i = 0; i <= PIPE_LAT; i++) dl[i] = '0;
        forever begin
            @(negedge iCLK);
            #2;
            if (iRST) begin
                acc_pend = 0;
                for (int i = 0; i < NTAP; i++) sh[i] = '0;
                for (int i = 0; i <= PIPE_LAT; i++) dl[i] = '0;
                iPsum_res = '0;
            end else begin
                for (int i = PIPE_LAT; i > 0; i--) dl[i] = dl[i-1];
                if (acc_pend) begin
                    logic [DW-1:0] p;
                    p = oW[DW-1:0] * oX;
                    for (int i = 1; i < NTAP; i++) p = p + oW[i*DW +: DW] * sh[i-1];
                    for (int i = NTAP - 1; i > 0; i--) sh[i] = sh[i-1];
                    sh[0] = oX;
                    dl[0] = p;
                end else begin
                    dl[0] = $urandom;
                end
                acc_pend = iX_valid && oX_ready;
                iPsum_res = dl[PIPE_LAT];
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge iCLK);
            #1;
            if (!iRST) begin
                check("credits_bound", 64'(oDbg_credits <= CRW'(FDEPTH)), 64'd1);
                check("psum_seed_zero", 64'(oPsum), 64'd0);
                if (oY_valid) begin
                    if (first_y_cyc < 0) first_y_cyc = cyc;
                    if (iY_ready) begin
                        n_beats++;
                        check("y_beat_expected", 64'(exp_q.size() > 0), 64'd1);
                        if (exp_q.size() > 0) check("y_data", 64'(oY_data), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // drivers
    task automatic offer_now(input bit done_at_last);
        iX_valid = 1'b0;
        iDone = 1'b0;
        if (rand_ready) iY_ready = 1'($urandom_range(0, 1));
        if (pend_x.size() > 0) begin
            iX_valid = 1'b1;
            iX_data = pend_x[0];
            if (oX_ready) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc + 1;
                model_accept(pend_x[0]);
                void'(pend_x.pop_front());
                n_acc++;
                if (done_at_last && pend_x.size() == 0) iDone = 1'b1;
            end
        end
    endtask

    task automatic pump(input int ncyc, input bit done_at_last);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge iCLK);
            offer_now(done_at_last);
        end
        @(negedge iCLK);
        iX_valid = 1'b0;
        iDone = 1'b0;
    endtask

    task automatic load_weights();
        int k = 0;
        int guard = 0;
        @(negedge iCLK);
        iCfg_start = 1'b1;
        @(negedge iCLK);
        iCfg_start = 1'b0;
        while (k < NTAP && guard < 100) begin
            iW_valid = 1'b1;
            iW_data = w_next[k];
            if (k == 3) begin
                check("partial_tap2_new", 64'(oW[2*DW +: DW]), 64'(w_next[2]));
                check("partial_tap3_old", 64'(oW[3*DW +: DW]), 64'(w_model[3]));
            end
            if (oW_ready) k++;
            @(negedge iCLK);
            guard++;
        end
        iW_valid = 1'b0;
        check("load_accepts", 64'(k), 64'(NTAP));
        check("load_state_run", 64'(oDbg_state), 64'(ST_RUN));
        check("load_w_ready_low", 64'(oW_ready), 64'd0);
        for (int i = 0; i < NTAP; i++) w_model[i] = w_next[i];
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge iCLK);
            g++;
        end
        @(negedge iCLK);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 64'(oDbg_state), 64'(ST_IDLE));
        check({tag, "_credits"}, 64'(oDbg_credits), 64'(FDEPTH));
        check({tag, "_busy"}, 64'(oBusy), 64'd0);
        check({tag, "_w_ready"}, 64'(oW_ready), 64'd0);
        check({tag, "_x_ready"}, 64'(oX_ready), 64'd0);
        check({tag, "_y_valid"}, 64'(oY_valid), 64'd0);
        check({tag, "_ox"}, 64'(oX), 64'd0);
        check({tag, "_ow_zero"}, 64'(oW == '0), 64'd1);
    endtask

    // main sequence
    initial begin
        iRST = 1'b1; iCfg_start = 1'b0; iW_valid = 1'b0; iW_data = '0;
        iX_valid = 1'b0; iX_data = '0; iDone = 1'b0; iY_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge iCLK);
        check_reset_outputs("rst_held");
        iRST = 1'b0;
        @(negedge iCLK);
        check_reset_outputs("rst_released");

        // weights 1..20
        for (int i = 0; i < NTAP; i++) w_next[i] = DW'(i + 1);
        load_weights();
        for (int i = 0; i < NTAP; i++) check("tap_value", 64'(oW[i*DW +: DW]), 64'(i + 1));

        // start pulse outside IDLE is ignored
        iCfg_start = 1'b1;
        @(negedge iCLK);
        iCfg_start = 1'b0;
        check("cfg_ignored_in_run", 64'(oDbg_state), 64'(ST_RUN));

        // x = 1,2,3 with consumer always ready
        iY_ready = 1'b1;
        n_beats = 0; first_acc_cyc = -1; first_y_cyc = -1;
        pend_x.push_back(1); pend_x.push_back(2); pend_x.push_back(3);
        pump(3, 0);
        wait_drain("stream3_drained");
        check("stream3_beats", 64'(n_beats), 64'd3);
        check("first_result_latency", 64'(first_y_cyc - first_acc_cyc), 64'd5);

        // backpressure: 10 offered, credits admit 8
        iY_ready = 1'b0;
        n_acc = 0; n_beats = 0;
        for (int i = 0; i < 10; i++) pend_x.push_back($urandom);
        pump(20, 0);
        check("bp_accepted", 64'(n_acc), 64'(FDEPTH));
        check("bp_x_ready_low", 64'(oX_ready), 64'd0);
        check("bp_credits_zero", 64'(oDbg_credits), 64'd0);
        check("bp_fifo_valid", 64'(oY_valid), 64'd1);
        // one pop frees one credit
        @(negedge iCLK);
        iY_ready = 1'b1;
        @(negedge iCLK);
        iY_ready = 1'b0;
        check("pop_x_ready_back", 64'(oX_ready), 64'd1);
        check("pop_credits_one", 64'(oDbg_credits), 64'd1);
        // accept and pop on the same edge
        iY_ready = 1'b1;
        offer_now(0);
        @(negedge iCLK);
        iX_valid = 1'b0;
        check("acc_pop_credits_same", 64'(oDbg_credits), 64'd1);
        check("acc_pop_accepted", 64'(n_acc), 64'd9);
        pump(10, 0);
        wait_drain("bp_drained");
        check("bp_total_accepted", 64'(n_acc), 64'd10);
        check("bp_total_beats", 64'(n_beats), 64'd10);

        // iDone together with the 4th accept
        n_beats = 0;
        for (int i = 0; i < 4; i++) pend_x.push_back($urandom);
        pump(4, 1);
        begin
            int g = 0;
            while (oDbg_state != ST_IDLE && g < 60) begin
                @(negedge iCLK);
                g++;
            end
        end
        check("done_state_idle", 64'(oDbg_state), 64'(ST_IDLE));
        check("done_busy_low", 64'(oBusy), 64'd0);
        check("done_beats", 64'(n_beats), 64'd4);
        check("done_queue_empty", 64'(exp_q.size()), 64'd0);

        // reset with 4 tags in flight and 2 FIFO entries
        for (int i = 0; i < NTAP; i++) w_next[i] = $urandom;
        load_weights();
        iY_ready = 1'b0;
        for (int i = 0; i < 6; i++) pend_x.push_back($urandom);
        pump(6, 0);
        @(negedge iCLK);
        check("pre_reset_fifo_valid", 64'(oY_valid), 64'd1);
        iRST = 1'b1;
        #1;
        check_reset_outputs("mid_run_rst");
        model_reset();
        @(negedge iCLK);
        iRST = 1'b0;
        iY_ready = 1'b1;
        n_beats = 0;
        repeat (20) @(negedge iCLK);
        check("post_reset_no_beats", 64'(n_beats), 64'd0);

        // randomized run with random consumer stalls
        for (int i = 0; i < NTAP; i++) w_next[i] = $urandom_range(0, 2000) - 1000;
        load_weights();
        n_acc = 0; n_beats = 0;
        for (int i = 0; i < 30; i++) pend_x.push_back($urandom);
        rand_ready = 1;
        pump(120, 0);
        rand_ready = 0;
        iY_ready = 1'b1;
        wait_drain("rand_drained");
        check("rand_accepted", 64'(n_acc), 64'd30);
        check("rand_beats", 64'(n_beats), 64'd30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
